// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key/scan outputs of ps2_key_decoder.
// The slave modport is the decoder side; the master modport is the device/consumer side.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport slave (
        input  ps2_clk, ps2_data,
        output key, scan_code, scan_valid, frame_err
    );

    modport master (
        output ps2_clk, ps2_data,
        input  key, scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder producing one-hot menu key pulses.
// Define KEY_REPEAT_EN to let typematic repeats of a held key pulse again.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frame_state_e;

    typedef enum logic [1:0] {
        D_BASE,
        D_EXT,
        D_BRK,
        D_EXT_BRK
    } dec_state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    frame_state_e fstate_q, fstate_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic          good_byte;
    logic          frame_bad;
    logic          timeout;

    always_comb begin
        fstate_d  = fstate_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tocnt_d   = tocnt_q;
        good_byte = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;

        if (fall) begin
            tocnt_d = '0;
            unique case (fstate_q)
                F_IDLE: begin
                    if (!ps2_data_s) begin
                        fstate_d = F_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                F_DATA: begin
                    shift_d  = {ps2_data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) fstate_d = F_PARITY;
                end
                F_PARITY: begin
                    par_d    = ps2_data_s;
                    fstate_d = F_STOP;
                end
                F_STOP: begin
                    // Odd parity: data bits plus parity bit carry an odd number of ones.
                    if (ps2_data_s && (^{par_q, shift_q})) good_byte = 1'b1;
                    else                                   frame_bad = 1'b1;
                    fstate_d = F_IDLE;
                end
                default: fstate_d = F_IDLE;
            endcase
        end else if (fstate_q == F_IDLE) begin
            tocnt_d = '0;
        end else if (tocnt_q == TO_LAST) begin
            // Counter holds at its last value; IDLE clears it on the next cycle.
            timeout  = 1'b1;
            fstate_d = F_IDLE;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder (consumes good bytes only)
    // ------------------------------------------------------------------
    dec_state_e dstate_q, dstate_d;
    logic [3:0] held_q, held_d;
    logic [3:0] key_d;
    logic [3:0] kmatch;
    logic       is_make;
    logic       is_rel;
    logic       is_ext;

    always_comb begin
        dstate_d = dstate_q;
        held_d   = held_q;
        key_d    = 4'b0000;
        is_make  = 1'b0;
        is_rel   = 1'b0;
        is_ext   = 1'b0;
        kmatch   = 4'b0000;

        if (good_byte) begin
            unique case (dstate_q)
                D_BASE: begin
                    if (shift_q == CODE_EXT)      dstate_d = D_EXT;
                    else if (shift_q == CODE_BRK) dstate_d = D_BRK;
                    else                          is_make  = 1'b1;
                end
                D_EXT: begin
                    if (shift_q == CODE_BRK) begin
                        dstate_d = D_EXT_BRK;
                    end else begin
                        is_make  = 1'b1;
                        is_ext   = 1'b1;
                        dstate_d = D_BASE;
                    end
                end
                D_BRK: begin
                    is_rel   = 1'b1;
                    dstate_d = D_BASE;
                end
                D_EXT_BRK: begin
                    is_rel   = 1'b1;
                    is_ext   = 1'b1;
                    dstate_d = D_BASE;
                end
                default: dstate_d = D_BASE;
            endcase
        end

        // Codes are distinct, so at most one bit of kmatch is ever set.
        kmatch[0] =  is_ext && (shift_q == CODE_UP);
        kmatch[1] =  is_ext && (shift_q == CODE_DOWN);
        kmatch[2] = !is_ext && (shift_q == CODE_ENTER);
        kmatch[3] = !is_ext && (shift_q == CODE_ESC);

        if (is_make) begin
`ifdef KEY_REPEAT_EN
            key_d  = kmatch;
`else
            key_d  = kmatch & ~held_q;
`endif
            held_d = held_q | kmatch;
        end else if (is_rel) begin
            held_d = held_q & ~kmatch;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [3:0] key_q;
    logic [7:0] scan_code_q;
    logic       scan_valid_q;
    logic       frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate_q     <= F_IDLE;
            bitcnt_q     <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tocnt_q      <= '0;
            dstate_q     <= D_BASE;
            held_q       <= 4'b0000;
            key_q        <= 4'b0000;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            fstate_q     <= fstate_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tocnt_q      <= tocnt_d;
            dstate_q     <= dstate_d;
            held_q       <= held_d;
            key_q        <= key_d;
            scan_valid_q <= good_byte;
            frame_err_q  <= frame_bad | timeout;
            if (good_byte) scan_code_q <= shift_q;
        end
    end

    assign bus.key        = key_q;
    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule
